// File: rtl/lvds_pkg.sv
// Shared constants and the framer state type for the LVDS transmit path.
package lvds_pkg;

  localparam logic [31:0] SYNC_WORD = 32'h1ACF_FC1D;
  localparam logic [31:0] IDLE_WORD = 32'h5555_5555;
  localparam logic [7:0]  HDR_TAG   = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HDR,
    ST_PAYLOAD,
    ST_CHK
  } framer_state_e;

endpackage

// File: rtl/lvds_tx_fifo.sv
// Single-clock synchronous word FIFO feeding the framer. Head word is
// presented combinationally on pop_data; DEPTH must be a power of two >= 2.
module lvds_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];

  // Pointer/count update; a push while full is only taken alongside a pop.
  always_comb begin
    do_push  = push & (~full | pop);
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards any buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written at the tail pointer.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/lvds_tx_framer.sv
// Frames buffered payload words as SYNC, HDR, payload, CHK for a word-serial
// LVDS serializer. All framer state advances only on word_tick edges.
module lvds_tx_framer
  import lvds_pkg::*;
#(
  parameter int unsigned PAYLOAD_WORDS = 8,
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic                        clk64mhz,
  input  logic                        rst_n,
  input  logic [31:0]                 s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        word_tick,
  output logic [31:0]                 tx_data,
  output logic                        tx_en,
  output logic [7:0]                  seq,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IDX_W = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam logic [CNT_W-1:0] PW_CNT   = CNT_W'(PAYLOAD_WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_WORDS - 1);

  framer_state_e    state_q, state_d;
  logic [31:0]      tx_data_q, tx_data_d;
  logic             tx_en_q, tx_en_d;
  logic [7:0]       seq_q, seq_d;
  logic [31:0]      chk_q, chk_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             pop_req, fifo_pop, fifo_push;
  logic             fifo_full, fifo_empty;
  logic [31:0]      fifo_head;
  logic [CNT_W-1:0] fifo_cnt;
  logic             start_ok;
  logic [31:0]      hdr_word;

  assign fifo_push  = s_valid & s_ready;
  assign fifo_pop   = pop_req & ~fifo_empty;
  assign s_ready    = ~fifo_full;
  assign fifo_count = fifo_cnt;
  assign tx_data    = tx_data_q;
  assign tx_en      = tx_en_q;
  assign seq        = seq_q;

  lvds_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk64mhz),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (s_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-word selection; everything holds unless this edge is a word tick.
  always_comb begin
    start_ok  = (fifo_cnt >= PW_CNT);
    hdr_word  = {HDR_TAG, seq_q, 16'(PAYLOAD_WORDS)};
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_en_d   = tx_en_q;
    seq_d     = seq_q;
    chk_d     = chk_q;
    idx_d     = idx_q;
    pop_req   = 1'b0;
    if (word_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            tx_data_d = SYNC_WORD;
            tx_en_d   = 1'b1;
            state_d   = ST_SYNC;
          end else begin
            tx_data_d = IDLE_WORD;
            tx_en_d   = 1'b0;
          end
        end
        ST_SYNC: begin
          tx_data_d = hdr_word;
          chk_d     = hdr_word;
          state_d   = ST_HDR;
        end
        ST_HDR: begin
          pop_req   = 1'b1;
          tx_data_d = fifo_head;
          chk_d     = chk_q ^ fifo_head;
          idx_d     = '0;
          state_d   = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (idx_q < IDX_LAST) begin
            pop_req   = 1'b1;
            tx_data_d = fifo_head;
            chk_d     = chk_q ^ fifo_head;
            idx_d     = idx_q + IDX_W'(1);
          end else begin
            tx_data_d = chk_q;
            state_d   = ST_CHK;
          end
        end
        ST_CHK: begin
          seq_d = seq_q + 8'd1;
          if (start_ok) begin
            tx_data_d = SYNC_WORD;
            tx_en_d   = 1'b1;
            state_d   = ST_SYNC;
          end else begin
            tx_data_d = IDLE_WORD;
            tx_en_d   = 1'b0;
            state_d   = ST_IDLE;
          end
        end
        default: begin
          tx_data_d = IDLE_WORD;
          tx_en_d   = 1'b0;
          state_d   = ST_IDLE;
        end
      endcase
    end
  end

  // Framer registers; reset aborts any frame in flight.
  always_ff @(posedge clk64mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_data_q <= IDLE_WORD;
      tx_en_q   <= 1'b0;
      seq_q     <= '0;
      chk_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      seq_q     <= seq_d;
      chk_q     <= chk_d;
      idx_q     <= idx_d;
    end
  end

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Self-checking bench for lvds_tx_framer: directed vector table plus frame
// sequences driven against a word-queue model.
`timescale 1ns/1ps
module tb_lvds_tx_framer;

  logic        clk64mhz = 1'b0;
  logic        rst_n;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        word_tick;
  logic [31:0] tx_data;
  logic        tx_en;
  logic [7:0]  seq;
  logic [4:0]  fifo_count;

  lvds_tx_framer #(
    .PAYLOAD_WORDS (8),
    .FIFO_DEPTH    (16)
  ) dut (
    .clk64mhz   (clk64mhz),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .word_tick  (word_tick),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .seq        (seq),
    .fifo_count (fifo_count)
  );

  always #8 clk64mhz = ~clk64mhz;

  typedef struct {
    logic [31:0] data;
    logic        en;
    logic [7:0]  sq;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_q [$];
  logic [31:0] next_word;
  int          push_left;
  logic [7:0]  seq_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, return at the next negedge (outputs settled).
  task automatic cyc(input logic tick);
    logic accepted;
    word_tick = tick;
    if (push_left > 0) begin
      s_valid = 1'b1;
      s_data  = next_word;
    end else begin
      s_valid = 1'b0;
      s_data  = 32'hDEAD_BEEF;
    end
    accepted = (push_left > 0) && s_ready;
    @(negedge clk64mhz);
    if (accepted) begin
      model_q.push_back(next_word);
      next_word++;
      push_left--;
    end
  endtask

  // One 16-cycle word slot starting with a tick; word checked at start and end.
  task automatic slot(input string name, input logic [31:0] exp_data, input logic exp_en,
                      input bit check_full);
    cyc(1'b1);
    check({name, "_data"}, tx_data, exp_data);
    check({name, "_en"}, {31'd0, tx_en}, {31'd0, exp_en});
    if (check_full) begin
      cyc(1'b0);
      check("full_after_pop_count", {27'd0, fifo_count}, 32'd16);
      check("full_after_pop_ready", {31'd0, s_ready}, 32'd0);
      repeat (14) cyc(1'b0);
    end else begin
      repeat (15) cyc(1'b0);
    end
    check({name, "_hold"}, tx_data, exp_data);
  endtask

  // Expects a complete frame starting at the next tick, payload from the model.
  task automatic run_frame(input bit check_full);
    logic [31:0] hdr, chk, w;
    slot("sync", 32'h1ACF_FC1D, 1'b1, 1'b0);
    check("seq_out", {24'd0, seq}, {24'd0, seq_m});
    hdr = {8'hA5, seq_m, 16'h0008};
    slot("hdr", hdr, 1'b1, 1'b0);
    chk = hdr;
    for (int i = 0; i < 8; i++) begin
      if (model_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL model_empty: got 0 words expected >0");
        w = 32'h0;
      end else begin
        w = model_q.pop_front();
      end
      slot("payload", w, 1'b1, check_full && (i == 0));
      chk = chk ^ w;
    end
    slot("chk", chk, 1'b1, 1'b0);
    seq_m++;
  endtask

  task automatic do_reset();
    @(negedge clk64mhz);
    word_tick = 1'b0;
    s_valid   = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_tx_data", tx_data, 32'h5555_5555);
    check("rst_tx_en", {31'd0, tx_en}, 32'd0);
    check("rst_seq", {24'd0, seq}, 32'd0);
    check("rst_count", {27'd0, fifo_count}, 32'd0);
    check("rst_ready", {31'd0, s_ready}, 32'd1);
    repeat (2) @(negedge clk64mhz);
    rst_n = 1'b1;
    @(negedge clk64mhz);
    check("post_rst_tx_data", tx_data, 32'h5555_5555);
    check("post_rst_tx_en", {31'd0, tx_en}, 32'd0);
    check("post_rst_seq", {24'd0, seq}, 32'd0);
    check("post_rst_count", {27'd0, fifo_count}, 32'd0);
    check("post_rst_ready", {31'd0, s_ready}, 32'd1);
    model_q.delete();
    seq_m     = 8'd0;
    push_left = 0;
  endtask

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{32'h1ACF_FC1D, 1'b1, 8'd0};
    vecs[1]  = '{32'hA500_0008, 1'b1, 8'd0};
    vecs[2]  = '{32'h0000_0001, 1'b1, 8'd0};
    vecs[3]  = '{32'h0000_0002, 1'b1, 8'd0};
    vecs[4]  = '{32'h0000_0003, 1'b1, 8'd0};
    vecs[5]  = '{32'h0000_0004, 1'b1, 8'd0};
    vecs[6]  = '{32'h0000_0005, 1'b1, 8'd0};
    vecs[7]  = '{32'h0000_0006, 1'b1, 8'd0};
    vecs[8]  = '{32'h0000_0007, 1'b1, 8'd0};
    vecs[9]  = '{32'h0000_0008, 1'b1, 8'd0};
    vecs[10] = '{32'hA500_0000, 1'b1, 8'd0};
    vecs[11] = '{32'h5555_5555, 1'b0, 8'd1};

    rst_n     = 1'b0;
    word_tick = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    push_left = 0;
    next_word = '0;
    seq_m     = '0;

    // Reset state, then idle slots with nothing buffered.
    do_reset();
    for (int i = 0; i < 4; i++) slot("idle", 32'h5555_5555, 1'b0, 1'b0);

    // Single frame from a directed table.
    next_word = 32'h1;
    push_left = 8;
    repeat (10) cyc(1'b0);
    check("t37_count", {27'd0, fifo_count}, 32'd8);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1);
      check($sformatf("t37_v%0d_data", i), tx_data, vecs[i].data);
      check($sformatf("t37_v%0d_en", i), {31'd0, tx_en}, {31'd0, vecs[i].en});
      check($sformatf("t37_v%0d_seq", i), {24'd0, seq}, {24'd0, vecs[i].sq});
      repeat (15) cyc(1'b0);
    end
    check("t37_count_end", {27'd0, fifo_count}, 32'd0);

    // Two back-to-back frames from a 16-word fill.
    do_reset();
    next_word = 32'h100;
    push_left = 16;
    repeat (20) cyc(1'b0);
    check("t38_count", {27'd0, fifo_count}, 32'd16);
    check("t38_ready", {31'd0, s_ready}, 32'd0);
    run_frame(1'b0);
    run_frame(1'b0);
    slot("t38_idle", 32'h5555_5555, 1'b0, 1'b0);
    check("t38_seq", {24'd0, seq}, 32'd2);

    // Full FIFO with s_valid held high, then 256 frames and seq wrap.
    do_reset();
    next_word = 32'h1000;
    push_left = 32'h7FFF_FFFF;
    repeat (20) cyc(1'b0);
    check("t39_count", {27'd0, fifo_count}, 32'd16);
    check("t39_ready", {31'd0, s_ready}, 32'd0);
    run_frame(1'b1);
    for (int f = 1; f < 256; f++) run_frame(1'b0);
    check("t40_seq_model_wrap", {24'd0, seq_m}, 32'd0);
    run_frame(1'b0);

    // Reset in the middle of a frame (PAYLOAD, idx 3).
    do_reset();
    next_word = 32'hC000_0000;
    push_left = 12;
    repeat (14) cyc(1'b0);
    slot("t41_sync", 32'h1ACF_FC1D, 1'b1, 1'b0);
    slot("t41_hdr", 32'hA500_0008, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) slot("t41_pl", 32'hC000_0000 + i, 1'b1, 1'b0);
    cyc(1'b1);
    check("t41_idx3_data", tx_data, 32'hC000_0003);
    repeat (3) cyc(1'b0);
    do_reset();
    slot("t41_idle", 32'h5555_5555, 1'b0, 1'b0);
    check("t41_count", {27'd0, fifo_count}, 32'd0);
    next_word = 32'hD000_0000;
    push_left = 8;
    repeat (10) cyc(1'b0);
    run_frame(1'b0);
    slot("t41_idle_end", 32'h5555_5555, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
